// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - circular FIFO feeding taken-branch resolutions to the BTB write port,
// with in-place coalescing of same-PC updates and a saturating drop counter.
module btb_update_queue #(
  parameter int DEPTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN-1:0]            in_taken,
  input  logic [NUM_IN*32-1:0]         in_branch_PC,
  input  logic [NUM_IN*32-1:0]         in_target_PC,
  output logic                         resolving_valid,
  output logic [31:0]                  resolving_branch_PC,
  output logic [31:0]                  resolving_target_PC,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [7:0]                   drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [PW-1:0]    head, tail, tail_n;
  logic [DEPTH-1:0] live, live_n;
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [31:0]      pc_n  [DEPTH];
  logic [31:0]      tgt_n [DEPTH];
  logic             pop;
  logic             hit;
  logic [OW-1:0]    free_n, allocs;
  logic [7:0]       drops;
  logic [8:0]       drop_sum;

  assign resolving_valid     = (occupancy != '0);
  assign resolving_branch_PC = resolving_valid ? pc_q[head]  : 32'd0;
  assign resolving_target_PC = resolving_valid ? tgt_q[head] : 32'd0;

  // The popped head is retired before the search so it can never absorb a coalesce;
  // entries allocated earlier in the same cycle are searchable, which merges same-PC inputs.
  always_comb begin
    pop    = (occupancy != '0);
    live_n = live;
    pc_n   = pc_q;
    tgt_n  = tgt_q;
    tail_n = tail;
    free_n = OW'(DEPTH) - occupancy + OW'(pop);
    allocs = '0;
    drops  = '0;
    hit    = 1'b0;
    if (pop) live_n[head] = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i] && in_taken[i]) begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (!hit && live_n[k] && (pc_n[k] == in_branch_PC[i*32 +: 32])) begin
            tgt_n[k] = in_target_PC[i*32 +: 32];
            hit      = 1'b1;
          end
        end
        if (!hit) begin
          if (free_n != '0) begin
            live_n[tail_n] = 1'b1;
            pc_n[tail_n]   = in_branch_PC[i*32 +: 32];
            tgt_n[tail_n]  = in_target_PC[i*32 +: 32];
            tail_n         = tail_n + PW'(1);
            free_n         = free_n - OW'(1);
            allocs         = allocs + OW'(1);
          end else begin
            drops = drops + 8'd1;
          end
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + {1'b0, drops};

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      drop_count <= '0;
      live       <= '0;
    end else begin
      head       <= head + PW'(pop);
      tail       <= tail_n;
      occupancy  <= occupancy + allocs - OW'(pop);
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      live       <= live_n;
    end
  end

  always_ff @(posedge clock) begin
    pc_q  <= pc_n;
    tgt_q <= tgt_n;
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - directed bench for btb_update_queue with a queue-based reference model.
module tb_btb_update_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_taken;
  logic [63:0] in_branch_PC, in_target_PC;
  logic        resolving_valid;
  logic [31:0] resolving_branch_PC, resolving_target_PC;
  logic [3:0]  occupancy;
  logic [7:0]  drop_count;

  always #5 clock = ~clock;

  btb_update_queue #(.DEPTH(8), .NUM_IN(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_taken(in_taken),
    .in_branch_PC(in_branch_PC), .in_target_PC(in_target_PC),
    .resolving_valid(resolving_valid),
    .resolving_branch_PC(resolving_branch_PC),
    .resolving_target_PC(resolving_target_PC),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  typedef struct { logic [31:0] pc; logic [31:0] tgt; } ent_t;
  ent_t mq[$];
  ent_t ment;
  int   mdrop = 0;
  int   midx;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: a plain queue; pop the head, then coalesce by PC search or append, else drop.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      mdrop = 0;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && in_taken[i]) begin
          midx = -1;
          for (int k = 0; k < mq.size(); k++)
            if (mq[k].pc == in_branch_PC[i*32 +: 32]) midx = k;
          if (midx >= 0) mq[midx].tgt = in_target_PC[i*32 +: 32];
          else if (mq.size() < 8) begin
            ment.pc  = in_branch_PC[i*32 +: 32];
            ment.tgt = in_target_PC[i*32 +: 32];
            mq.push_back(ment);
          end else mdrop = (mdrop < 255) ? mdrop + 1 : 255;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_valid", {31'd0, resolving_valid}, {31'd0, mq.size() != 0});
      chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
      chk("m_drop_count", 32'(drop_count), 32'(mdrop));
      if (mq.size() != 0) begin
        chk("m_branch_PC", resolving_branch_PC, mq[0].pc);
        chk("m_target_PC", resolving_target_PC, mq[0].tgt);
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] tk,
                       input logic [31:0] p0, input logic [31:0] t0,
                       input logic [31:0] p1, input logic [31:0] t1);
    in_valid     = v;
    in_taken     = tk;
    in_branch_PC = {p1, p0};
    in_target_PC = {t1, t0};
    @(negedge clock);
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0; in_taken = '0; in_branch_PC = '0; in_target_PC = '0;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    cmp_en = 1'b1;

    for (int c = 0; c < 10; c++) begin
      idle();
      chk("idle_valid", {31'd0, resolving_valid}, 32'd0);
      chk("idle_occupancy", 32'(occupancy), 32'd0);
      chk("idle_drop", 32'(drop_count), 32'd0);
    end
    chk("idle_branch_PC", resolving_branch_PC, 32'd0);
    chk("idle_target_PC", resolving_target_PC, 32'd0);

    drive(2'b01, 2'b01, 32'h100, 32'h200, 0, 0);
    chk("single_valid", {31'd0, resolving_valid}, 32'd1);
    chk("single_pc", resolving_branch_PC, 32'h100);
    chk("single_tgt", resolving_target_PC, 32'h200);
    idle();
    chk("single_after", {31'd0, resolving_valid}, 32'd0);

    drive(2'b11, 2'b00, 32'h700, 32'h1, 32'h704, 32'h2);
    chk("not_taken_valid", {31'd0, resolving_valid}, 32'd0);

    drive(2'b11, 2'b11, 32'h100, 32'h200, 32'h104, 32'h300);
    chk("dual_first_pc", resolving_branch_PC, 32'h100);
    idle();
    chk("dual_second_pc", resolving_branch_PC, 32'h104);
    chk("dual_second_tgt", resolving_target_PC, 32'h300);
    idle();
    chk("dual_after", {31'd0, resolving_valid}, 32'd0);

    drive(2'b11, 2'b11, 32'h0F0, 32'h1, 32'h100, 32'h200);
    chk("coal_occ_before", 32'(occupancy), 32'd2);
    drive(2'b10, 2'b10, 0, 0, 32'h100, 32'h400);
    chk("coal_occ_after", 32'(occupancy), 32'd1);
    chk("coal_pc", resolving_branch_PC, 32'h100);
    chk("coal_tgt", resolving_target_PC, 32'h400);
    idle();
    chk("coal_after", {31'd0, resolving_valid}, 32'd0);

    drive(2'b11, 2'b11, 32'h500, 32'h1, 32'h500, 32'h2);
    chk("samepc_occ", 32'(occupancy), 32'd1);
    chk("samepc_tgt", resolving_target_PC, 32'h2);
    idle();

    drive(2'b01, 2'b01, 32'h600, 32'h8, 0, 0);
    drive(2'b01, 2'b01, 32'h600, 32'h9, 0, 0);
    chk("headpop_occ", 32'(occupancy), 32'd1);
    chk("headpop_pc", resolving_branch_PC, 32'h600);
    chk("headpop_tgt", resolving_target_PC, 32'h9);
    idle();
    chk("headpop_after", {31'd0, resolving_valid}, 32'd0);

    for (int c = 0; c < 7; c++)
      drive(2'b11, 2'b11, 32'h1000 + 8*c, 32'h1010 + 8*c, 32'h1004 + 8*c, 32'h1014 + 8*c);
    chk("full_occ", 32'(occupancy), 32'd8);
    drive(2'b11, 2'b11, 32'h2000, 32'h2010, 32'h2004, 32'h2014);
    chk("fullpop_occ", 32'(occupancy), 32'd8);
    chk("fullpop_drop", 32'(drop_count), 32'd1);
    repeat (10) idle();
    chk("full_drained", {31'd0, resolving_valid}, 32'd0);

    for (int c = 0; c < 10; c++) begin
      drive(2'b11, 2'b11, 32'h3000 + 8*c, 32'h3100 + 8*c, 32'h3004 + 8*c, 32'h3104 + 8*c);
      idle();
    end
    chk("wrap_drop", 32'(drop_count), 32'd1);

    for (int c = 0; c < 310; c++)
      drive(2'b11, 2'b11, 32'h4000 + 8*c, 32'h9000 + 8*c, 32'h4004 + 8*c, 32'h9004 + 8*c);
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_occ", 32'(occupancy), 32'd8);

    reset = 1'b1;
    idle();
    chk("rst_valid", {31'd0, resolving_valid}, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;
    idle();
    chk("post_rst_valid", {31'd0, resolving_valid}, 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
